// File: rtl/sram_req_pkg.sv
// Shared types for the SRAM request controller: FSM state encoding and
// the width of the optional statistics counters.
package sram_req_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_DATA  = 2'd1,
        RSP_HOLD = 2'd2
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/sram_sat_cnt.sv
// Saturating up-counter used for request statistics; sticks at all-ones
// instead of wrapping.
module sram_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request/response front end for a registered-read SRAM: posted writes,
// one outstanding read. Define SRAM_REQ_CTRL_STATS_EN to add wr_cnt/rd_cnt.
//
// state    | meaning
// IDLE     | ready for a request; SRAM driven straight from the request
// RD_DATA  | SRAM read data valid this cycle, offered as the response
// RSP_HOLD | response stalled; data replayed from hold_data
module sram_req_ctrl
    import sram_req_pkg::*;
#(
    parameter int W  = 8,
    parameter int D  = 16,
    localparam int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [W-1:0]  req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_rdata,
    output logic [AW-1:0] rsp_addr,
    output logic          mem_w_en,
    output logic [AW-1:0] mem_ad,
    output logic [W-1:0]  mem_data_in,
    input  logic [W-1:0]  mem_data_out
`ifdef SRAM_REQ_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt
`endif
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  hold_data;
    logic          rd_accept;

    assign rd_accept = req_valid & req_ready & ~req_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr   <= '0;
            hold_data <= '0;
        end else begin
            state <= state_nxt;
            if (rd_accept) begin
                rd_addr <= req_addr;
            end
            // Capture the one-cycle SRAM data before the address can move on.
            if ((state == RD_DATA) && !rsp_ready) begin
                hold_data <= mem_data_out;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = hold_data;
        rsp_addr    = rd_addr;
        mem_w_en    = 1'b0;
        mem_ad      = rd_addr;
        mem_data_in = req_wdata;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                mem_w_en  = req_valid & req_we & ~rst;
                mem_ad    = req_addr;
                if (rd_accept) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                rsp_valid = 1'b1;
                rsp_rdata = mem_data_out;
                state_nxt = rsp_ready ? IDLE : RSP_HOLD;
            end
            RSP_HOLD: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SRAM_REQ_CTRL_STATS_EN
    sram_sat_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk (clk),
        .rst (rst),
        .inc (req_valid & req_ready & req_we),
        .cnt (wr_cnt)
    );

    sram_sat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rd_accept),
        .cnt (rd_cnt)
    );
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural SRAM plus an array reference model
// of memory contents and request counts; directed cases then random traffic.
module tb_sram_req_ctrl;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = $clog2(D);

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic [AW-1:0] rsp_addr;
    logic          mem_w_en;
    logic [AW-1:0] mem_ad;
    logic [W-1:0]  mem_data_in;
    logic [W-1:0]  mem_data_out;
`ifdef SRAM_REQ_CTRL_STATS_EN
    logic [15:0]   wr_cnt;
    logic [15:0]   rd_cnt;
`endif

    logic [W-1:0]  sram [D];
    logic [W-1:0]  ref_mem [D];
    int            wr_exp;
    int            rd_exp;
    int            n_total;
    int            n_bad;

    sram_req_ctrl #(.W(W), .D(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_addr     (rsp_addr),
        .mem_w_en     (mem_w_en),
        .mem_ad       (mem_ad),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
`ifdef SRAM_REQ_CTRL_STATS_EN
        ,
        .wr_cnt       (wr_cnt),
        .rd_cnt       (rd_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read SRAM: data for the sampled address appears after the edge.
    always @(posedge clk) begin
        if (mem_w_en) sram[mem_ad] <= mem_data_in;
        mem_data_out <= sram[mem_ad];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        check_eq("wr_ready", 32'(req_ready), 32'd1);
        check_eq("wr_en", 32'(mem_w_en), 32'd1);
        check_eq("wr_ad", 32'(mem_ad), 32'(a));
        check_eq("wr_din", 32'(mem_data_in), 32'(d));
        check_eq("wr_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        ref_mem[a] = d;
        wr_exp++;
    endtask

    // Read with rsp_ready held low for 'hold' cycles after data appears.
    task automatic do_read(input logic [AW-1:0] a, input int hold);
        logic [W-1:0] exp_d;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("rd_ready", 32'(req_ready), 32'd1);
        check_eq("rd_no_wen", 32'(mem_w_en), 32'd0);
        check_eq("rd_ad", 32'(mem_ad), 32'(a));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rd_exp++;
        exp_d = ref_mem[a];
        rsp_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_data", 32'(rsp_rdata), 32'(exp_d));
            check_eq("hold_addr", 32'(rsp_addr), 32'(a));
            check_eq("hold_noready", 32'(req_ready), 32'd0);
            check_eq("hold_mem_ad", 32'(mem_ad), 32'(a));
            @(posedge clk);
            #1;
            if (h == hold - 1) rsp_ready = 1'b1;
        end
        @(negedge clk);
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_data", 32'(rsp_rdata), 32'(exp_d));
        check_eq("rsp_addr", 32'(rsp_addr), 32'(a));
        check_eq("rsp_noready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("back_idle", 32'(req_ready), 32'd1);
        check_eq("rsp_drop", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wen_cycles;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        n_total   = 0;
        n_bad     = 0;
        wr_exp    = 0;
        rd_exp    = 0;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        #12;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_wen", 32'(mem_w_en), 32'd0);
        check_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst_raddr", 32'(rsp_addr), 32'd0);
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Known contents everywhere before any read.
        for (int i = 0; i < D; i++) do_write(AW'(i), W'($urandom));

        do_write(AW'(3), 8'hA5);
        do_read(AW'(3), 0);
        do_read(AW'(3), 3);

        do_write(AW'(15), 8'h3C);
        do_read(AW'(15), 0);
        do_write(AW'(0), 8'h01);
        do_read(AW'(0), 0);

        // Reset in RD_DATA drops the read.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(7);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        #1;
        check_eq("midrst_valid", 32'(rsp_valid), 32'd0);
        check_eq("midrst_ready", 32'(req_ready), 32'd0);
        check_eq("midrst_wen", 32'(mem_w_en), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        rst       = 1'b0;
        wr_exp    = 0;
        rd_exp    = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_norsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        do_write(AW'(9), 8'h5A);
        do_read(AW'(9), 0);

        // Writes to 0..9 each followed by a read.
        for (int i = 0; i < 10; i++) begin
            do_write(AW'(i), W'($urandom));
            do_read(AW'(i), 0);
        end

        // Back-to-back writes for five cycles.
        wen_cycles = 0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = AW'($urandom_range(0, D - 1));
            d = W'($urandom);
            req_addr  = a;
            req_wdata = d;
            @(negedge clk);
            if (mem_w_en) wen_cycles++;
            check_eq("b2b_ready", 32'(req_ready), 32'd1);
            check_eq("b2b_norsp", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
            ref_mem[a] = d;
            wr_exp++;
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        check_eq("b2b_wen_cycles", 32'(wen_cycles), 32'd5);
        @(negedge clk);
        check_eq("b2b_end_norsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < D; i++) do_read(AW'(i), 0);

        // Random mix.
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom_range(0, D - 1));
            if ($urandom_range(0, 1) == 1) do_write(a, W'($urandom));
            else do_read(a, int'($urandom_range(0, 3)));
        end

`ifdef SRAM_REQ_CTRL_STATS_EN
        @(negedge clk);
        check_eq("wr_cnt", 32'(wr_cnt), 32'(wr_exp));
        check_eq("rd_cnt", 32'(rd_cnt), 32'(rd_exp));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
